// File: rtl/wb_uart_tx_fifo.sv
// wb_uart_tx_fifo
//   Wishbone-slave UART transmitter with a byte FIFO. Serial format is 8N1,
//   LSB first. The bit time is DIV+1 clocks, where DIV is set by software.
//
//   Register window, selected by wbs_adr_i[3:2]:
//     0 TXDATA  W  push dat[7:0] when sel[0] is set; a push into a full FIFO
//                  is dropped and sets OVF. Reads 0.
//     1 STATUS  R  [0] empty, [1] full, [2] busy, [3] OVF, [15:8] level
//     2 DIV     RW [15:0] with byte lanes per sel[1:0]
//     3 CTRL    RW [0] EN, [1] IRQ_EN, [2] write-1 clears OVF (reads 0)
//
//   Ports
//     wb_clk_i, wb_rst_n_i      clock and asynchronous active-low reset
//     wbs_cyc_i/stb_i/we_i      Wishbone cycle, strobe and write enable
//     wbs_sel_i[3:0]            byte-lane selects
//     wbs_adr_i[31:0]           byte address
//     wbs_dat_i[31:0]           write data
//     wbs_ack_o                 registered single-cycle acknowledge
//     wbs_dat_o[31:0]           read data, zero when not acknowledging a read
//     uart_tx_o                 serial line, idle high
//     uart_oeb_o                pad output-enable bar, tied low
//     irq_o                     registered level interrupt
module wb_uart_tx_fifo #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        uart_tx_o,
  output logic        uart_oeb_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Bus interface
  logic        ack_q;
  logic [31:0] dat_q;
  logic        hit_s;
  logic        wr_s;
  logic [1:0]  reg_s;
  logic [31:0] rd_data_s;
  logic [31:0] status_s;

  // Software-visible registers
  logic [15:0] div_q, div_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          empty_s, full_s;
  logic          push_req_s, push_s, pop_s;

  // Transmitter
  state_e      state_q;
  logic [7:0]  shift_q;
  logic [15:0] div_lat_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic        tx_q;
  logic        irq_q;
  logic        busy_s;

  // Inputs that no register decodes.
  logic unused_s;
  assign unused_s = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

  // The !ack_q term makes a held strobe produce one ack every other cycle.
  assign hit_s   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
  assign wr_s    = hit_s & wbs_we_i;
  assign reg_s   = wbs_adr_i[3:2];

  assign empty_s = (level_q == {(AW + 1){1'b0}});
  assign full_s  = (level_q == DEPTH_C);
  assign busy_s  = (state_q != IDLE);

  // Full is the pre-edge value, so a same-edge pop never makes room for a push.
  assign push_req_s = wr_s & (reg_s == 2'd0) & wbs_sel_i[0];
  assign push_s     = push_req_s & ~full_s;
  assign pop_s      = (state_q == IDLE) & en_q & ~empty_s;

  assign status_s = {16'h0000, 8'(level_q), 4'h0, ovf_q, busy_s, full_s, empty_s};

  // Read-data multiplexer
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (reg_s)
      2'd0:    rd_data_s = 32'h0000_0000;
      2'd1:    rd_data_s = status_s;
      2'd2:    rd_data_s = {16'h0000, div_q};
      2'd3:    rd_data_s = {30'h0000_0000, irq_en_q, en_q};
      default: rd_data_s = 32'h0000_0000;
    endcase
  end

  // Next-state values for DIV, CTRL and OVF from bus writes
  always_comb begin
    div_d    = div_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    if (wr_s) begin
      case (reg_s)
        2'd0: begin
          if (push_req_s && full_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        2'd2: begin
          if (wbs_sel_i[0]) begin
            div_d[7:0] = wbs_dat_i[7:0];
          end else begin
            div_d[7:0] = div_q[7:0];
          end
          if (wbs_sel_i[1]) begin
            div_d[15:8] = wbs_dat_i[15:8];
          end else begin
            div_d[15:8] = div_q[15:8];
          end
        end
        2'd3: begin
          if (wbs_sel_i[0]) begin
            en_d     = wbs_dat_i[0];
            irq_en_d = wbs_dat_i[1];
            if (wbs_dat_i[2]) begin
              ovf_d = 1'b0;
            end else begin
              ovf_d = ovf_q;
            end
          end else begin
            en_d = en_q;
          end
        end
        default: begin
          div_d = div_q;
        end
      endcase
    end else begin
      div_d = div_q;
    end
  end

  // Wishbone acknowledge and registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'h0000_0000;
    end else begin
      ack_q <= hit_s;
      dat_q <= (hit_s && !wbs_we_i) ? rd_data_s : 32'h0000_0000;
    end
  end

  // Software-visible register state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      div_q    <= DEFAULT_DIV;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while level is zero
  always_ff @(posedge wb_clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wbs_dat_i[7:0];
    end
  end

  // FIFO pointers and fill level; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + {{AW{1'b0}}, 1'b1};
        2'b01:   level_q <= level_q - {{AW{1'b0}}, 1'b1};
        default: level_q <= level_q;
      endcase
    end
  end

  // Transmit FSM; DIV is latched at pop so mid-frame DIV writes wait for the next frame
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      div_lat_q <= 16'h0000;
      cnt_q     <= 16'h0000;
      bit_q     <= 3'd0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop_s) begin
            shift_q   <= mem_q[rd_ptr_q];
            div_lat_q <= div_q;
            cnt_q     <= 16'h0000;
            tx_q      <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (cnt_q == div_lat_q) begin
            cnt_q   <= 16'h0000;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == div_lat_q) begin
            cnt_q <= 16'h0000;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              // Shift first so shift_q[0] is always the bit on the line.
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == div_lat_q) begin
            cnt_q   <= 16'h0000;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Interrupt: transmitter drained and idle, one cycle behind its inputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & empty_s & ~busy_s;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign uart_tx_o  = tx_q;
  assign uart_oeb_o = 1'b0;
  assign irq_o      = irq_q;

endmodule
